// File: rtl/mmm_systolic_sequencer.sv
// mmm_systolic_sequencer
//   Control sequencer for the bit-serial systolic Montgomery multiplier array.
//   It latches operand A and clears the PE partial-result registers. It then
//   feeds A to the array LSB first, one bit per cycle, and flushes the
//   pipeline for DRAIN cycles. Finally it pulses done / result_capture.
//
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   start           run request, honoured only in IDLE
//   abort           synchronous cancel of any in-flight run
//   a_in[WIDTH]     operand A, latched on the accepted start edge
//   busy            CLEAR / ITER / DRAIN
//   done            one-cycle completion pulse
//   result_capture  load strobe for the result register (== done)
//   pe_clear        clear PE partial results (CLEAR only)
//   pe_en           PE register enable (ITER and DRAIN)
//   a_valid         ai_bit carries an A bit (ITER only)
//   ai_bit          current A bit, 0 outside ITER
//   iter_cnt[CNT_W] cycle index across ITER+DRAIN, 0 elsewhere
//
// All outputs decode from registered state only. There is no path from
// start, abort or a_in to an output.
module mmm_systolic_sequencer #(
  parameter  int WIDTH = 8,
  parameter  int DRAIN = 2,
  localparam int CNT_W = $clog2(WIDTH + DRAIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  output logic             busy,
  output logic             done,
  output logic             result_capture,
  output logic             pe_clear,
  output logic             pe_en,
  output logic             a_valid,
  output logic             ai_bit,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ITER, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(WIDTH + DRAIN - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sh  <= '0;
      cnt   <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      a_sh  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            a_sh  <= a_in;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          // Shift with zero fill, so a_sh is already clear when ITER ends.
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          if (cnt == LAST_A) begin
            if (DRAIN > 0) begin
              cnt   <= cnt + ONE;
              state <= S_DRAIN;
            end else begin
              cnt   <= '0;
              state <= S_DONE;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_DRAIN: begin
          if (cnt == LAST_D) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          a_sh  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy           = (state == S_CLEAR) || (state == S_ITER) || (state == S_DRAIN);
  assign done           = (state == S_DONE);
  assign result_capture = done;
  assign pe_clear       = (state == S_CLEAR);
  assign pe_en          = (state == S_ITER) || (state == S_DRAIN);
  assign a_valid        = (state == S_ITER);
  assign ai_bit         = a_valid & a_sh[0];
  // cnt is held at 0 outside ITER/DRAIN, so it can be exported directly.
  assign iter_cnt       = cnt;

endmodule

// File: tb/tb_mmm_systolic_sequencer.sv
module tb_mmm_systolic_sequencer;

  localparam int CW = 4;  // clog2(8+2+1) and clog2(8+0+1) are both 4

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [7:0] a_in = '0;
  logic start0 = 1'b0, abort0 = 1'b0;
  logic [7:0] a_in0 = '0;

  logic busy, done, rc, pclr, pen, av, ai;
  logic [CW-1:0] cnt;
  logic busy0, done0, rc0, pclr0, pen0, av0, ai0;
  logic [CW-1:0] cnt0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mmm_systolic_sequencer #(.WIDTH(8), .DRAIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a_in(a_in),
    .busy(busy), .done(done), .result_capture(rc), .pe_clear(pclr),
    .pe_en(pen), .a_valid(av), .ai_bit(ai), .iter_cnt(cnt));

  mmm_systolic_sequencer #(.WIDTH(8), .DRAIN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .a_in(a_in0),
    .busy(busy0), .done(done0), .result_capture(rc0), .pe_clear(pclr0),
    .pe_en(pen0), .a_valid(av0), .ai_bit(ai0), .iter_cnt(cnt0));

  // Output bundle {busy,done,rc,pe_clear,pe_en,a_valid,ai_bit,iter_cnt}
  wire [10:0] obs  = {busy, done, rc, pclr, pen, av, ai, cnt};
  wire [10:0] obs0 = {busy0, done0, rc0, pclr0, pen0, av0, ai0, cnt0};

  // Expected bundle k cycles after the accepting edge E0 (sampled after Ek).
  function automatic logic [10:0] exp_vec(input int k, input logic [7:0] a, input int drain);
    logic [10:0] e;
    e = '0;
    if (k == 0)                       e = 11'b1_0_0_1_0_0_0_0000;
    else if (k >= 1 && k <= 8)        e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a[k-1], CW'(k-1)};
    else if (k >= 9 && k < 9 + drain) e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(k-1)};
    else if (k == 9 + drain)          e = 11'b0_1_1_0_0_0_0_0000;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 11'd0) $display("FAIL reset_outputs: got %b want %b", obs, 11'd0);
    else passed++;
    total++;
    if (obs0 !== 11'd0) $display("FAIL reset_outputs_d0: got %b want %b", obs0, 11'd0);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    start = 1'b1; a_in = 8'hA5;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (obs !== exp_vec(k, 8'hA5, 2))
        $display("FAIL normal_k%0d: got %b want %b", k, obs, exp_vec(k, 8'hA5, 2));
      else passed++;
    end
  endtask

  task automatic test_hold_start();
    start = 1'b1; a_in = 8'hA5;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 4) a_in = 8'hFF;
      total++;
      if (obs !== exp_vec(k, 8'hA5, 2))
        $display("FAIL hold_k%0d: got %b want %b", k, obs, exp_vec(k, 8'hA5, 2));
      else passed++;
    end
    // start still high after the IDLE cycle: second run uses 8'hFF
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (obs !== exp_vec(k, 8'hFF, 2))
        $display("FAIL hold2_k%0d: got %b want %b", k, obs, exp_vec(k, 8'hFF, 2));
      else passed++;
    end
  endtask

  task automatic test_abort();
    start = 1'b1; a_in = 8'hA5;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (obs !== exp_vec(k, 8'hA5, 2))
        $display("FAIL abort_pre_k%0d: got %b want %b", k, obs, exp_vec(k, 8'hA5, 2));
      else passed++;
    end
    abort = 1'b1;  // iter_cnt == 3 here
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      abort = 1'b0;
      total++;
      if (obs !== 11'd0) $display("FAIL abort_idle_%0d: got %b want %b", k, obs, 11'd0);
      else passed++;
    end
    start = 1'b1; a_in = 8'h3C;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (obs !== exp_vec(k, 8'h3C, 2))
        $display("FAIL abort_rerun_k%0d: got %b want %b", k, obs, exp_vec(k, 8'h3C, 2));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; a_in = 8'hA5;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (obs !== exp_vec(9, 8'hA5, 2)) $display("FAIL rst_mid_drain: got %b want %b", obs, exp_vec(9, 8'hA5, 2));
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 11'd0) $display("FAIL rst_mid_async: got %b want %b", obs, 11'd0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (obs !== 11'd0) $display("FAIL rst_mid_nodone_%0d: got %b want %b", k, obs, 11'd0);
      else passed++;
    end
    start = 1'b1; a_in = 8'h01;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (obs !== exp_vec(k, 8'h01, 2))
        $display("FAIL rst_rerun_k%0d: got %b want %b", k, obs, exp_vec(k, 8'h01, 2));
      else passed++;
    end
  endtask

  task automatic test_drain0();
    start0 = 1'b1; a_in0 = 8'h80;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      total++;
      if (obs0 !== exp_vec(k, 8'h80, 0))
        $display("FAIL drain0_k%0d: got %b want %b", k, obs0, exp_vec(k, 8'h80, 0));
      else passed++;
    end
  endtask

  task automatic test_abort_start();
    start = 1'b1; abort = 1'b1; a_in = 8'h5A;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; a_in = 8'h00;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs !== 11'd0) $display("FAIL abort_start_idle_%0d: got %b want %b", k, obs, 11'd0);
      else passed++;
      @(negedge clk);
    end
    start = 1'b1; a_in = 8'h3C;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (obs !== exp_vec(k, 8'h3C, 2))
        $display("FAIL abort_start_run_k%0d: got %b want %b", k, obs, exp_vec(k, 8'h3C, 2));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hold_start();
    test_abort();
    test_reset_mid();
    test_drain0();
    test_abort_start();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
